conv_middle_res_rmw: RTL and testbench
======================================

Name: conv_middle_res_rmw

Overview:
- Read-modify-write controller for the convolution middle-result buffer.
- Accepts aligned partial sums (exponent, fraction/fixed-point, buffer address) from the multiply-add tree.
- Fetches the stored middle result, drives the middle-result accumulator input interface, and writes the accumulator output back to the buffer.
- Forwards final sums (last pass) downstream and stalls upstream on in-flight read-after-write hazards to the same address.

Parameters:
- ADDR_W, 10, middle-result buffer address width.
- MAX_INFLIGHT, 4, maximum packets between acceptance and write-back (includes stage-1 register); range 2..8.
- SIM_DELAY, 1, simulation delay on register assignments.

Ports:
- aclk  in  1  clock
- areset  in  1  reset
- s_exp  in  8  partial-sum exponent (FP16 mode only; passed through unchanged)
- s_frac  in  40  signed fraction or fixed-point partial sum
- s_addr  in  ADDR_W  middle-result buffer address
- s_first  in  1  first item: no buffer read, original middle result = 0
- s_last  in  1  final pass: result also emitted on m_res
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- buf_ren  out  1  buffer read enable
- buf_raddr  out  ADDR_W  buffer read address
- buf_rdata  in  32  buffer read data, 1-cycle latency, read-old-on-collision
- buf_wen  out  1  buffer write enable
- buf_waddr  out  ADDR_W  buffer write address
- buf_wdata  out  32  buffer write data
- acmlt_in_exp  out  8  to accumulator
- acmlt_in_frac  out  40  to accumulator
- acmlt_in_org_mid_res  out  32  to accumulator
- acmlt_in_first_item  out  1  to accumulator
- acmlt_in_valid  out  1  to accumulator
- acmlt_out_data  in  32  accumulator result (FP32 or INT32)
- acmlt_out_valid  in  1  accumulator result valid
- m_res_data  out  32  final result
- m_res_addr  out  ADDR_W  final result address
- m_res_valid  out  1  final result valid; no backpressure
- err_unexpected_out  out  1  sticky: acmlt_out_valid seen with no tag outstanding

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
  - While areset is high at a rising aclk edge, the stage-1 valid, tag FIFO pointers and count, and err_unexpected_out are cleared to 0.
  - All outputs are 0 during and after reset (s_ready = 0 while areset is high).
  - A reset mid-operation drops all in-flight packets; no write-back occurs for them.
- Accept: happens when s_valid and s_ready are both high.
  - s_ready = !areset && (inflight < MAX_INFLIGHT) && !hit.
  - inflight = stage-1 valid + tag FIFO count.
- Hazard (hit): s_first = 0 and s_addr equals the address of the valid stage-1 entry or any tag FIFO entry.
  - An entry clears at the cycle its write-back occurs, so a read may issue in the cycle after the write.
  - s_first = 1 never hits.
- Read (combinational on accept): buf_ren = accept && !s_first; buf_raddr = s_addr.
- Stage 1: registers exp, frac, addr, first, last on accept. Next cycle (latency 1):
  - acmlt_in_valid = 1.
  - acmlt_in_org_mid_res = first ? 0 : buf_rdata.
  - Other acmlt_in_* come from stage-1 registers and hold their last value when not valid.
- Tag FIFO: depth MAX_INFLIGHT, holds {addr, last}; pushed when acmlt_in_valid = 1. The accumulator is in-order with arbitrary latency.
- Write-back (combinational on acmlt_out_valid with FIFO non-empty):
  - buf_wen = 1; buf_waddr = head addr; buf_wdata = acmlt_out_data; tag popped.
  - If head last = 1: m_res_valid = 1, m_res_data = acmlt_out_data, m_res_addr = head addr.
- Simultaneous push and pop: count unchanged. Accept and pop in the same cycle: inflight is evaluated before the pop (conservative).
- acmlt_out_valid with FIFO empty: no write, no m_res, err_unexpected_out set to 1 until reset.
- Full: inflight = MAX_INFLIGHT forces s_ready = 0 regardless of hazard.

Test Plan:
- Single first item (addr 5, frac 252, first = 1, last = 1), accumulator model latency 3 returns 252:
  - buf_ren stays 0; acmlt_in_valid 1 cycle after accept with org_mid_res = 0.
  - 3 cycles later: buf_wen with addr 5, data 252; m_res_valid with data 252, addr 5.
- Non-first item, addr 7, buffer preloaded 100, frac 8:
  - buf_ren/raddr 7 at accept; org_mid_res = 100; write-back 108 to addr 7; m_res_valid = 0 when last = 0.
- Back-to-back same address 3 (first then non-first), latency 4:
  - s_ready low for the second item until the cycle after buf_wen to addr 3.
  - Second item reads the updated value; final buffer content = sum of both.
- Different addresses 0..7 streamed with s_valid held high, latency 6:
  - s_ready drops when inflight = 4; writes land in order 0..7 with no data loss.
- acmlt_out_valid pulsed with nothing outstanding:
  - err_unexpected_out = 1 and stays 1; no buf_wen.
  - areset clears it and all valids.
- Reset asserted with 3 packets in flight:
  - No subsequent buf_wen or m_res_valid for them; s_ready = 1 after reset with FIFO empty.

Source files
------------

// File: rtl/conv_middle_res_rmw.sv
// ----------------------------------------------------------------------------
// conv_middle_res_rmw
//   Read-modify-write controller for the convolution middle-result buffer.
//   A partial sum from the multiply-add tree is accepted. Unless it is the
//   first item for its address, the stored middle result is read (1-cycle
//   buffer latency). The pair is then handed to the middle-result accumulator,
//   and the accumulator result is written back to the buffer. On the final
//   pass the result is also forwarded on m_res_*. A new item whose address is
//   still between acceptance and write-back is held off so that it always
//   reads the updated value.
//
// Ports
//   aclk, areset               clock, synchronous active-high reset
//   s_exp/s_frac/s_addr        partial sum: exponent, fraction, buffer address
//   s_first/s_last             first item (no read, org = 0) / final pass
//   s_valid/s_ready            input handshake
//   buf_ren/buf_raddr          buffer read port (combinational on accept)
//   buf_rdata                  buffer read data, one cycle after buf_ren
//   buf_wen/buf_waddr/buf_wdata buffer write port (combinational on result)
//   acmlt_in_*                 accumulator input, one cycle after accept
//   acmlt_out_data/valid       in-order accumulator result
//   m_res_data/addr/valid      final sums, no backpressure
//   err_unexpected_out         sticky: result seen with no tag outstanding
// ----------------------------------------------------------------------------
module conv_middle_res_rmw #(
   parameter int ADDR_W       = 10,
   parameter int MAX_INFLIGHT = 4,
   parameter int SIM_DELAY    = 1
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [7:0]        s_exp,
   input  logic [39:0]       s_frac,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic              s_first,
   input  logic              s_last,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              buf_ren,
   output logic [ADDR_W-1:0] buf_raddr,
   input  logic [31:0]       buf_rdata,
   output logic              buf_wen,
   output logic [ADDR_W-1:0] buf_waddr,
   output logic [31:0]       buf_wdata,
   output logic [7:0]        acmlt_in_exp,
   output logic [39:0]       acmlt_in_frac,
   output logic [31:0]       acmlt_in_org_mid_res,
   output logic              acmlt_in_first_item,
   output logic              acmlt_in_valid,
   input  logic [31:0]       acmlt_out_data,
   input  logic              acmlt_out_valid,
   output logic [31:0]       m_res_data,
   output logic [ADDR_W-1:0] m_res_addr,
   output logic              m_res_valid,
   output logic              err_unexpected_out
);

   localparam int PTR_W = (MAX_INFLIGHT > 2) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

   // Register updates carry no delay in this implementation; SIM_DELAY is
   // kept only for interface compatibility. Out-of-range settings elaborate
   // an empty marker block that is easy to spot in a hierarchy dump.
   if (MAX_INFLIGHT < 2 || MAX_INFLIGHT > 8 || SIM_DELAY < 0) begin : g_param_out_of_range
   end

   // Stage-1 registers (the packet whose buffer read is in flight)
   logic              s1_valid_r;
   logic [7:0]        s1_exp_r;
   logic [39:0]       s1_frac_r;
   logic [ADDR_W-1:0] s1_addr_r;
   logic              s1_first_r;
   logic              s1_last_r;

   // Tag FIFO: one entry per packet sitting inside the accumulator
   logic [ADDR_W-1:0]       tag_addr_r [MAX_INFLIGHT];
   logic                    tag_last_r [MAX_INFLIGHT];
   logic [MAX_INFLIGHT-1:0] slot_valid_r;
   logic [PTR_W-1:0]        wr_ptr_r;
   logic [PTR_W-1:0]        rd_ptr_r;
   logic [CNT_W-1:0]        count_r;
   logic                    err_r;

   logic [CNT_W-1:0]  inflight_s;
   logic              hit_s;
   logic              ready_s;
   logic              accept_s;
   logic              push_s;
   logic              pop_s;
   logic              fifo_empty_s;
   logic              unexpected_s;
   logic [ADDR_W-1:0] head_addr_s;
   logic              head_last_s;

   // Pointer advance with wrap, so depths that are not a power of two work
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(MAX_INFLIGHT - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Hazard detection: a non-first item may not read an address that is
   // still waiting for its write-back. The head entry counts until the edge
   // that completes its write.
   always_comb begin
      hit_s = s1_valid_r && (s1_addr_r == s_addr);
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
         hit_s = hit_s | (slot_valid_r[i] && (tag_addr_r[i] == s_addr));
      end
      hit_s = hit_s && !s_first;
   end

   // Handshake, FIFO control and write-back decode. Occupancy is taken before
   // any pop in the same cycle, which keeps the ready path short.
   always_comb begin
      inflight_s   = count_r + CNT_W'(s1_valid_r);
      ready_s      = !areset && (inflight_s < CNT_W'(MAX_INFLIGHT)) && !hit_s;
      accept_s     = s_valid && ready_s;
      push_s       = s1_valid_r;
      fifo_empty_s = (count_r == '0);
      pop_s        = !areset && acmlt_out_valid && !fifo_empty_s;
      unexpected_s = !areset && acmlt_out_valid && fifo_empty_s;
      head_addr_s  = tag_addr_r[rd_ptr_r];
      head_last_s  = tag_last_r[rd_ptr_r];
   end

   assign s_ready   = ready_s;
   assign buf_ren   = accept_s && !s_first;
   assign buf_raddr = areset ? '0 : s_addr;

   assign buf_wen   = pop_s;
   assign buf_waddr = pop_s ? head_addr_s : '0;
   assign buf_wdata = pop_s ? acmlt_out_data : 32'd0;

   assign m_res_valid = pop_s && head_last_s;
   assign m_res_data  = (pop_s && head_last_s) ? acmlt_out_data : 32'd0;
   assign m_res_addr  = (pop_s && head_last_s) ? head_addr_s : '0;

   assign acmlt_in_valid       = !areset && s1_valid_r;
   assign acmlt_in_exp         = areset ? 8'd0 : s1_exp_r;
   assign acmlt_in_frac        = areset ? 40'd0 : s1_frac_r;
   assign acmlt_in_first_item  = !areset && s1_first_r;
   assign acmlt_in_org_mid_res = (!areset && s1_valid_r && !s1_first_r) ? buf_rdata : 32'd0;

   assign err_unexpected_out = !areset && err_r;

   // Stage-1 register: captures the accepted packet while its read completes
   always_ff @(posedge aclk) begin
      if (areset) begin
         s1_valid_r <= 1'b0;
         s1_exp_r   <= 8'd0;
         s1_frac_r  <= 40'd0;
         s1_addr_r  <= '0;
         s1_first_r <= 1'b0;
         s1_last_r  <= 1'b0;
      end else begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_exp_r   <= s_exp;
            s1_frac_r  <= s_frac;
            s1_addr_r  <= s_addr;
            s1_first_r <= s_first;
            s1_last_r  <= s_last;
         end
      end
   end

   // Tag FIFO: push as the packet enters the accumulator, pop on its result.
   // A push never lands on the slot being popped because occupancy is capped.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
         count_r      <= '0;
         slot_valid_r <= '0;
      end else begin
         if (push_s) begin
            tag_addr_r[wr_ptr_r]   <= s1_addr_r;
            tag_last_r[wr_ptr_r]   <= s1_last_r;
            slot_valid_r[wr_ptr_r] <= 1'b1;
            wr_ptr_r               <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            slot_valid_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r               <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky flag for an accumulator result that had no matching tag
   always_ff @(posedge aclk) begin
      if (areset) begin
         err_r <= 1'b0;
      end else if (unexpected_s) begin
         err_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_middle_res_rmw.sv
// ----------------------------------------------------------------------------
// Bench for conv_middle_res_rmw. The environment models the buffer (1-cycle
// read, old data on collision) and an in-order INT32 accumulator with a
// selectable latency. A transaction-level model (list of outstanding packets
// plus the logical content of every address) predicts every output on every
// cycle; directed scenarios add a few hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_conv_middle_res_rmw;
   localparam int AW   = 10;
   localparam int MAXI = 4;

   logic          aclk = 1'b0;
   logic          areset;
   logic [7:0]    s_exp;
   logic [39:0]   s_frac;
   logic [AW-1:0] s_addr;
   logic          s_first, s_last, s_valid, s_ready;
   logic          buf_ren;
   logic [AW-1:0] buf_raddr;
   logic [31:0]   buf_rdata;
   logic          buf_wen;
   logic [AW-1:0] buf_waddr;
   logic [31:0]   buf_wdata;
   logic [7:0]    acmlt_in_exp;
   logic [39:0]   acmlt_in_frac;
   logic [31:0]   acmlt_in_org_mid_res;
   logic          acmlt_in_first_item, acmlt_in_valid;
   logic [31:0]   acmlt_out_data;
   logic          acmlt_out_valid;
   logic [31:0]   m_res_data;
   logic [AW-1:0] m_res_addr;
   logic          m_res_valid, err_unexpected_out;

   conv_middle_res_rmw #(.ADDR_W(AW), .MAX_INFLIGHT(MAXI), .SIM_DELAY(1)) dut (
      .aclk(aclk), .areset(areset),
      .s_exp(s_exp), .s_frac(s_frac), .s_addr(s_addr), .s_first(s_first),
      .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
      .buf_ren(buf_ren), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
      .buf_wen(buf_wen), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .acmlt_in_exp(acmlt_in_exp), .acmlt_in_frac(acmlt_in_frac),
      .acmlt_in_org_mid_res(acmlt_in_org_mid_res),
      .acmlt_in_first_item(acmlt_in_first_item), .acmlt_in_valid(acmlt_in_valid),
      .acmlt_out_data(acmlt_out_data), .acmlt_out_valid(acmlt_out_valid),
      .m_res_data(m_res_data), .m_res_addr(m_res_addr), .m_res_valid(m_res_valid),
      .err_unexpected_out(err_unexpected_out)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [AW-1:0] addr;
      logic          first;
      logic          last;
      logic [39:0]   frac;
      logic [7:0]    exp;
      logic [31:0]   org;
      int            acc_cyc;
   } pkt_t;
   typedef struct { int due; logic [31:0] data; } acc_t;
   typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cyc; } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] mem     [1024];
   logic [31:0] logical [1024];
   pkt_t        outq[$];
   acc_t        accq[$];
   wr_t         wlog[$];
   int          acc_lat = 3;
   logic [31:0] next_rdata = 32'd0;
   logic        err_exp = 1'b0;
   bit          inj_pulse = 1'b0;
   int          wen_cnt = 0, mres_cnt = 0, max_out = 0, last_acc_cyc = 0;
   logic [31:0] last_mres_data = 32'd0;
   logic [AW-1:0] last_mres_addr = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle model compare plus buffer/accumulator environment bookkeeping
   always @(negedge aclk) begin : model
      bit   hit, exp_ready, in_exp, elig;
      pkt_t p;
      acc_t a;
      wr_t  w;
      if (areset) begin
         chk("reset_valids", 64'({s_ready, buf_ren, buf_wen, acmlt_in_valid,
                                  m_res_valid, err_unexpected_out}), 64'd0);
         chk("reset_data", 64'(|{buf_raddr, buf_waddr, buf_wdata, acmlt_in_exp,
                                 acmlt_in_frac, acmlt_in_org_mid_res,
                                 acmlt_in_first_item, m_res_data, m_res_addr}), 64'd0);
         outq.delete();
         accq.delete();
         err_exp = 1'b0;
         for (int i = 0; i < 1024; i++) logical[i] = mem[i];
      end else begin
         hit = 1'b0;
         foreach (outq[i]) if (outq[i].addr == s_addr) hit = 1'b1;
         exp_ready = (outq.size() < MAXI) && !(hit && !s_first);
         chk("s_ready", 64'(s_ready), 64'(exp_ready));
         chk("buf_ren", 64'(buf_ren), 64'(s_valid && exp_ready && !s_first));
         if (buf_ren) chk("buf_raddr", 64'(buf_raddr), 64'(s_addr));

         in_exp = (outq.size() > 0) && (outq[$].acc_cyc == cyc - 1);
         chk("acmlt_in_valid", 64'(acmlt_in_valid), 64'(in_exp));
         if (in_exp) begin
            chk("acmlt_in_org", 64'(acmlt_in_org_mid_res), 64'(outq[$].org));
            chk("acmlt_in_frac", 64'(acmlt_in_frac), 64'(outq[$].frac));
            chk("acmlt_in_exp", 64'(acmlt_in_exp), 64'(outq[$].exp));
            chk("acmlt_in_first", 64'(acmlt_in_first_item), 64'(outq[$].first));
         end

         elig = (outq.size() > 0) && (outq[0].acc_cyc <= cyc - 2);
         chk("buf_wen", 64'(buf_wen), 64'(acmlt_out_valid && elig));
         chk("m_res_valid", 64'(m_res_valid), 64'(acmlt_out_valid && elig && outq[0].last));
         chk("err_unexpected_out", 64'(err_unexpected_out), 64'(err_exp));
         if (acmlt_out_valid && elig) begin
            chk("buf_waddr", 64'(buf_waddr), 64'(outq[0].addr));
            chk("buf_wdata", 64'(buf_wdata), 64'(acmlt_out_data));
            chk("wb_sum", 64'(buf_wdata), 64'(outq[0].org + outq[0].frac[31:0]));
            if (outq[0].last) begin
               chk("m_res_data", 64'(m_res_data), 64'(acmlt_out_data));
               chk("m_res_addr", 64'(m_res_addr), 64'(outq[0].addr));
            end
            w.addr = buf_waddr; w.data = buf_wdata; w.cyc = cyc;
            wlog.push_back(w);
            void'(outq.pop_front());
         end else if (acmlt_out_valid) begin
            err_exp = 1'b1;
         end

         if (buf_wen) wen_cnt++;
         if (m_res_valid) begin
            mres_cnt++;
            last_mres_data = m_res_data;
            last_mres_addr = m_res_addr;
         end
         if (buf_ren) next_rdata = mem[buf_raddr];
         if (buf_wen) mem[buf_waddr] = buf_wdata;
         if (acmlt_in_valid) begin
            a.due  = cyc + acc_lat;
            a.data = acmlt_in_org_mid_res + acmlt_in_frac[31:0];
            accq.push_back(a);
         end
         if (s_valid && s_ready) begin
            p.addr = s_addr; p.first = s_first; p.last = s_last;
            p.frac = s_frac; p.exp = s_exp; p.acc_cyc = cyc;
            p.org  = s_first ? 32'd0 : logical[s_addr];
            logical[s_addr] = p.org + s_frac[31:0];
            outq.push_back(p);
            last_acc_cyc = cyc;
         end
         if (outq.size() > max_out) max_out = outq.size();
      end
   end

   // Environment drivers: buffer read data and accumulator results
   always @(posedge aclk) begin
      #1;
      cyc++;
      buf_rdata = next_rdata;
      if (accq.size() > 0 && accq[0].due <= cyc) begin
         acmlt_out_valid = 1'b1;
         acmlt_out_data  = accq[0].data;
         void'(accq.pop_front());
      end else if (inj_pulse) begin
         acmlt_out_valid = 1'b1;
         acmlt_out_data  = 32'h1234_5678;
         inj_pulse       = 1'b0;
      end else begin
         acmlt_out_valid = 1'b0;
         acmlt_out_data  = 32'hDEAD_BEEF;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic send(input logic [AW-1:0] addr, input logic [39:0] frac,
                       input logic [7:0] exp, input logic first, input logic last);
      int budget;
      s_addr = addr; s_frac = frac; s_exp = exp; s_first = first; s_last = last;
      s_valid = 1'b1;
      budget = 0;
      forever begin
         @(negedge aclk);
         if (s_ready) break;
         budget++;
         if (budget > 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: addr %0d never accepted", addr);
            break;
         end
      end
      @(posedge aclk);
      #1;
      s_valid = 1'b0;
   endtask

   initial begin
      int wc, mc, base;
      areset = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
      s_addr = '0; s_frac = 40'd0; s_exp = 8'd0;
      buf_rdata = 32'd0; acmlt_out_valid = 1'b0; acmlt_out_data = 32'd0;
      for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; logical[i] = 32'd0; end
      idle(3);
      areset = 1'b0;

      // Single first item, latency 3
      acc_lat = 3;
      send(10'd5, 40'd252, 8'h3C, 1'b1, 1'b1);
      idle(10);
      chk("t1_mem5", 64'(mem[5]), 64'd252);
      chk("t1_mres_data", 64'(last_mres_data), 64'd252);
      chk("t1_mres_addr", 64'(last_mres_addr), 64'd5);
      chk("t1_wb_latency", 64'(wlog[$].cyc - last_acc_cyc), 64'd4);

      // Non-first item onto a preloaded address, not last
      mem[7] = 32'd100; logical[7] = 32'd100;
      mc = mres_cnt;
      send(10'd7, 40'd8, 8'h01, 1'b0, 1'b0);
      idle(10);
      chk("t2_mem7", 64'(mem[7]), 64'd108);
      chk("t2_no_mres", 64'(mres_cnt), 64'(mc));

      // Back-to-back same address with latency 4
      acc_lat = 4;
      send(10'd3, 40'd20, 8'h02, 1'b1, 1'b0);
      send(10'd3, 40'd22, 8'h03, 1'b0, 1'b1);
      idle(12);
      chk("t3_mem3", 64'(mem[3]), 64'd42);
      chk("t3_release", 64'(last_acc_cyc), 64'(wlog[wlog.size()-2].cyc + 1));

      // Stream addresses 0..7 with latency 6
      acc_lat = 6;
      for (int i = 0; i < 8; i++) begin mem[i] = 32'(10 * i); logical[i] = 32'(10 * i); end
      max_out = 0;
      base = wlog.size();
      for (int i = 0; i < 8; i++) send(10'(i), 40'(i + 1), 8'(i), 1'b0, 1'b1);
      idle(15);
      chk("t4_write_count", 64'(wlog.size() - base), 64'd8);
      chk("t4_max_inflight", 64'(max_out), 64'd4);
      for (int i = 0; i < 8; i++) begin
         if (base + i < wlog.size()) begin
            chk("t4_order_addr", 64'(wlog[base+i].addr), 64'(i));
            chk("t4_order_data", 64'(wlog[base+i].data), 64'(11 * i + 1));
         end
      end

      // Unexpected accumulator result
      wc = wen_cnt;
      inj_pulse = 1'b1;
      idle(3);
      chk("t5_err_set", 64'(err_unexpected_out), 64'd1);
      idle(5);
      chk("t5_err_sticky", 64'(err_unexpected_out), 64'd1);
      chk("t5_no_wen", 64'(wen_cnt), 64'(wc));
      areset = 1'b1;
      idle(2);
      areset = 1'b0;
      idle(1);
      chk("t5_err_cleared", 64'(err_unexpected_out), 64'd0);

      // Reset with three packets in flight
      acc_lat = 10;
      send(10'd40, 40'd1, 8'h00, 1'b1, 1'b1);
      send(10'd41, 40'd2, 8'h00, 1'b1, 1'b1);
      send(10'd42, 40'd3, 8'h00, 1'b1, 1'b1);
      idle(2);
      areset = 1'b1;
      idle(2);
      areset = 1'b0;
      wc = wen_cnt; mc = mres_cnt;
      idle(20);
      chk("t6_no_wen", 64'(wen_cnt), 64'(wc));
      chk("t6_no_mres", 64'(mres_cnt), 64'(mc));
      chk("t6_mem40", 64'(mem[40]), 64'd0);
      s_first = 1'b1; s_addr = 10'd40;
      @(negedge aclk);
      chk("t6_ready_after_reset", 64'(s_ready), 64'd1);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
